fetch_unit: RTL

- Instruction-fetch stage directly downstream of the next-PC logic in the single-cycle-derived MIPS core.
- Owns the architectural fetch PC register and issues word-aligned reads to instruction memory over a valid/ready request channel; memory latency is variable.
- Buffers returned instructions with their PCs in a small FIFO toward decode.
- Applies redirects (branch/jump targets computed by the next-PC unit), discarding stale in-flight data.

---
 rtl/fetch_unit_pkg.sv | 25 ++
 rtl/fetch_unit_if.sv | 38 +++
 rtl/fetch_unit_fifo.sv | 62 ++++++
 rtl/fetch_unit.sv | 96 +++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch slice: reset address,
// instruction width, fetch FSM state type, buffer entry layout and a
// word-alignment helper.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam int unsigned INSTR_W          = 32;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Low two address bits are ignored: every fetch is a whole word.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle for fetch_unit.
//   redirect_valid/redirect_pc : next-PC unit requests a non-sequential fetch
//   imem_req_*                 : valid/ready read request to instruction memory
//   imem_rsp_*                 : in-order read response (one per accepted request)
//   id_*                       : valid/ready instruction stream toward decode
// master = fetch unit side, slave = surrounding core/memory side.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [31:0]        imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               id_valid;
  logic               id_ready;
  logic [31:0]        id_pc;
  logic [INSTR_W-1:0] id_instr;

  modport master (
    input  redirect_valid, redirect_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  id_ready,
    output imem_req_valid, imem_req_addr,
    output id_valid, id_pc, id_instr
  );

  modport slave (
    output redirect_valid, redirect_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output id_ready,
    input  imem_req_valid, imem_req_addr,
    input  id_valid, id_pc, id_instr
  );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Fetch buffer: DEPTH-entry synchronous FIFO of {pc, instr} entries.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   flush      : empties the buffer (same effect as reset on occupancy)
//   push, push_data : write an entry (accepted when not full, or when full
//                     with a simultaneous pop)
//   pop        : remove head entry (ignored when empty)
//   head       : head entry
//   empty      : no entries held
//   count      : current occupancy (0..DEPTH)
module fetch_unit_fifo
  import fetch_unit_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         empty,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full buffer may still accept.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the fetch PC, issues one word read at a time
// to instruction memory, buffers returned instructions with their PCs for
// decode, and applies redirects from the next-PC unit, discarding any
// in-flight or buffered stale instructions.
// Ports:
//   clk   : core clock, all state on rising edge
//   reset : synchronous active-high reset
//   bus   : fetch_unit_if.master (redirect, imem request/response, decode)
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 2
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;

  logic          req_valid_int;
  logic          req_fire;
  logic          rsp;
  logic          redirect;
  logic          push;
  logic          pop;
  fetch_entry_t  push_data;
  fetch_entry_t  head;
  logic          empty;
  logic [CW-1:0] count;

  assign redirect      = bus.redirect_valid;
  assign rsp           = bus.imem_rsp_valid;
  assign req_valid_int = (state == FETCH) && (count < CW'(DEPTH));
  assign req_fire      = req_valid_int && bus.imem_req_ready;

  // Only WAIT owns a live response; DRAIN swallows it, redirect drops it.
  assign push      = (state == WAIT) && rsp && !redirect;
  assign pop       = !empty && bus.id_ready && !redirect;
  assign push_data = '{pc: req_pc, instr: bus.imem_rsp_data};

  fetch_unit_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .flush     (redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else if (redirect) begin
      fetch_pc <= word_align(bus.redirect_pc);
      // A request accepted now, or still owed, must be drained before refetch.
      case (state)
        FETCH:       state <= req_fire ? DRAIN : FETCH;
        WAIT, DRAIN: state <= rsp ? FETCH : DRAIN;
        default:     state <= FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (req_fire) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
            state    <= WAIT;
          end
        end
        WAIT:    if (rsp) state <= FETCH;
        DRAIN:   if (rsp) state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  assign bus.imem_req_valid = reset ? 1'b0 : req_valid_int;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.id_valid       = reset ? 1'b0 : !empty;
  assign bus.id_pc          = (reset || empty) ? '0 : head.pc;
  assign bus.id_instr       = (reset || empty) ? '0 : head.instr;

endmodule
